hub75_rx: RTL
=============

Name: hub75_rx

Overview:
- HUB75 panel-side receiver: the far end of the interface CubeTop drives, used as a self-checking sink in simulation and as a loopback monitor on hardware.
- Oversamples the HUB75 pins on osc_clk, shifts in the column data, and on each latch replays the captured line as a pixel stream.
- Measures the output-enable (OE) on-time per latch so BCM bitplane weights can be checked.

Parameters:
- PANEL_WIDTH, 32, columns shifted per line.
- ROW_BITS, 3, width of hub75_row.
- OE_CNT_BITS, 16, width of the OE on-time counter. The counter saturates.

Ports:
- osc_clk  in  1  system clock; every flop in the block is on this clock.
- reset_  in  1  asynchronous, active-low reset.
- hub75_clk  in  1  HUB75 shift clock; asynchronous to osc_clk.
- hub75_lat  in  1  HUB75 latch, active high.
- hub75_oe_  in  1  HUB75 output enable, active low.
- hub75_row  in  ROW_BITS  row address.
- hub75_r0/g0/b0/r1/g1/b1  in  1 each  upper and lower half colour data.
- pix_valid  out  1  pixel stream valid.
- pix_ready  in  1  pixel stream ready.
- pix_row  out  ROW_BITS  row captured at latch.
- pix_col  out  $clog2(PANEL_WIDTH)  column; 0 = first bit shifted in.
- pix_rgb0  out  3  {r0,g0,b0}.
- pix_rgb1  out  3  {r1,g1,b1}.
- pix_last  out  1  high on column PANEL_WIDTH-1.
- oe_valid  out  1  one-cycle pulse when OE deasserts.
- oe_row  out  ROW_BITS  synced row at OE deassert.
- oe_cycles  out  OE_CNT_BITS  osc_clk cycles OE was low.
- err_short  out  1  sticky: latch arrived with column count != PANEL_WIDTH.
- err_drop  out  1  sticky: latch arrived while the previous line was still streaming.

Behaviour:
- Reset (reset_ low, asynchronous):
  - All outputs 0. Column count 0. FSM to IDLE.
  - Synchronizer flops reset to the idle bus levels: clk=0, lat=0, oe_=1.
- Input capture:
  - All 12 HUB75 inputs pass through a 2-flop synchronizer, then one edge-detect stage.
  - hub75_clk must stay high and low for at least 2 osc_clk cycles each. The shift clock must not exceed osc_clk/4.
- Shift:
  - Each synced hub75_clk rising edge writes the synced 6 data bits into shift_buf[col_cnt].
  - col_cnt increments and saturates at PANEL_WIDTH. Writes at saturation are discarded.
- Latch (synced hub75_lat rising edge, cycle N):
  - If col_cnt != PANEL_WIDTH, set err_short.
  - If FSM is IDLE: copy shift_buf to hold_buf, capture synced row into pix_row, clear col_cnt, enter SEND. pix_valid is high from N+1.
  - If FSM is SEND: the line is dropped, err_drop is set, col_cnt is cleared, and hold_buf is untouched.
  - A clock edge and a latch edge in the same cycle: the shift write happens first, then the latch sees the incremented col_cnt.
- Output FSM:
  - States are IDLE and SEND.
  - In SEND: pix_col starts at 0 and pix_valid stays high. pix_col and the data on pix_rgb0/pix_rgb1 hold stable until pix_valid && pix_ready.
  - On each handshake pix_col advances.
  - The handshake with pix_last = 1 returns the FSM to IDLE, and pix_valid drops the next cycle.
  - Throughput is 1 pixel per cycle when pix_ready is held high.
- OE measure:
  - Counter clears on the synced oe_ falling edge and increments each cycle while synced oe_ is low. It saturates at all-ones.
  - On the synced oe_ rising edge: oe_valid pulses for 1 cycle with oe_cycles equal to the count and oe_row equal to the synced row.
  - oe_cycles holds its value until the next pulse.
  - OE measurement is independent of the shift/latch path.
- Reset mid-operation: the current line is discarded with no partial output, and the sticky errors clear.
- Sticky errors clear only on reset.

Decomposition:
- hub75_pkg holds:
  - the default panel constants: PANEL_WIDTH, ROW_BITS.
  - the colour-field positions within the 6-bit sample: r0=0 … b1=5.
  - the pixel struct typedef {row, col, rgb0, rgb1, last}, so CubeTop-side code and the bench share one layout.
- One sub-module, hub75_rx_sync: the 2-flop synchronizer plus rise/fall detect for clk, lat and oe_.
  - The data and row bits pass through the same synchronizer with no edge detect.

Test Plan:
- Nominal line: shift 32 columns with column i data = i mod 64, then latch with row 5, pix_ready held 1 -> 32 beats, pix_col 0..31, {rgb1,rgb0}=i, pix_row=5, pix_last only on col 31; no error flags set.
- Backpressure: same line with pix_ready toggling 1/0 -> each beat's pix_col and pix_rgb0/pix_rgb1 hold while not ready; 32 beats total, order preserved.
- Short line: 30 shift edges then latch -> err_short=1; 32 beats still emitted, cols 30-31 carry the previous line's data.
- Drop: two latches 4 osc_clk cycles apart with pix_ready=0 -> err_drop=1; the first line is streamed intact.
- OE timing: oe_ low for 100 osc_clk cycles with row 3 -> single oe_valid pulse with oe_cycles=100 (±1 for synchronizer alignment) and oe_row=3. With OE_CNT_BITS=4, a 40-cycle pulse -> oe_cycles=15.
- Reset mid-line: assert reset_ after 10 shift edges, release, shift a full line and latch -> output matches the new line only; no flags set.
- Full-system run: CubeTop outputs into hub75_rx -> no err_short or err_drop over 240000 cycles.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared HUB75 receiver definitions: default panel geometry, colour bit positions
// within a captured 6-bit sample, the output FSM states and the pixel beat layout.
package hub75_pkg;

    localparam int DEF_PANEL_WIDTH = 32;
    localparam int DEF_ROW_BITS    = 3;
    localparam int DEF_COL_BITS    = $clog2(DEF_PANEL_WIDTH);
    localparam int SAMPLE_BITS     = 6;

    localparam int R0_POS = 0;
    localparam int G0_POS = 1;
    localparam int B0_POS = 2;
    localparam int R1_POS = 3;
    localparam int G1_POS = 4;
    localparam int B1_POS = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic [DEF_ROW_BITS-1:0] row;
        logic [DEF_COL_BITS-1:0] col;
        logic [2:0]              rgb0;
        logic [2:0]              rgb1;
        logic                    last;
    } hub75_pix_t;

    function automatic logic [2:0] rgb0_of(input logic [SAMPLE_BITS-1:0] s);
        return {s[R0_POS], s[G0_POS], s[B0_POS]};
    endfunction

    function automatic logic [2:0] rgb1_of(input logic [SAMPLE_BITS-1:0] s);
        return {s[R1_POS], s[G1_POS], s[B1_POS]};
    endfunction

endpackage

// File: rtl/hub75_rx_sync.sv
// Two-flop synchronizer for every HUB75 pin plus one history stage on the control
// pins (clk, lat, oe_) to produce single-cycle edge strobes.
module hub75_rx_sync
    import hub75_pkg::*;
#(
    parameter int ROW_BITS = DEF_ROW_BITS
) (
    input  logic                   osc_clk,
    input  logic                   reset_,
    input  logic                   hub75_clk,
    input  logic                   hub75_lat,
    input  logic                   hub75_oe_,
    input  logic [ROW_BITS-1:0]    hub75_row,
    input  logic [SAMPLE_BITS-1:0] hub75_data,
    output logic [SAMPLE_BITS-1:0] sample_s,
    output logic [ROW_BITS-1:0]    row_s,
    output logic                   oe_n_s,
    output logic                   clk_rise,
    output logic                   lat_rise,
    output logic                   oe_fall,
    output logic                   oe_rise
);

    localparam int BUS_BITS = 3 + SAMPLE_BITS + ROW_BITS;
    // Bus layout {oe_, lat, clk, data, row}; reset to the idle pin levels.
    localparam logic [BUS_BITS-1:0] IDLE_BUS = {3'b100, {(SAMPLE_BITS + ROW_BITS){1'b0}}};

    logic [BUS_BITS-1:0] meta_q, meta_d;
    logic [BUS_BITS-1:0] sync_q, sync_d;
    logic [2:0]          prev_q, prev_d;
    logic [2:0]          ctl_s;

    always_comb begin
        meta_d = {hub75_oe_, hub75_lat, hub75_clk, hub75_data, hub75_row};
        sync_d = meta_q;
        prev_d = sync_q[BUS_BITS-1 -: 3];
    end

    always_ff @(posedge osc_clk or negedge reset_) begin
        if (!reset_) begin
            meta_q <= IDLE_BUS;
            sync_q <= IDLE_BUS;
            prev_q <= 3'b100;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign ctl_s    = sync_q[BUS_BITS-1 -: 3];
    assign sample_s = sync_q[ROW_BITS +: SAMPLE_BITS];
    assign row_s    = sync_q[ROW_BITS-1:0];
    assign oe_n_s   = ctl_s[2];
    assign clk_rise = ctl_s[0] & ~prev_q[0];
    assign lat_rise = ctl_s[1] & ~prev_q[1];
    assign oe_fall  = ~ctl_s[2] & prev_q[2];
    assign oe_rise  = ctl_s[2] & ~prev_q[2];

endmodule

// File: rtl/hub75_rx.sv
// HUB75 panel-side receiver: captures shifted column data, replays each latched
// line as a ready/valid pixel stream, and measures OE low time per pulse.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int PANEL_WIDTH = DEF_PANEL_WIDTH,
    parameter int ROW_BITS    = DEF_ROW_BITS,
    parameter int OE_CNT_BITS = 16
) (
    input  logic                           osc_clk,
    input  logic                           reset_,
    input  logic                           hub75_clk,
    input  logic                           hub75_lat,
    input  logic                           hub75_oe_,
    input  logic [ROW_BITS-1:0]            hub75_row,
    input  logic                           hub75_r0,
    input  logic                           hub75_g0,
    input  logic                           hub75_b0,
    input  logic                           hub75_r1,
    input  logic                           hub75_g1,
    input  logic                           hub75_b1,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [ROW_BITS-1:0]            pix_row,
    output logic [$clog2(PANEL_WIDTH)-1:0] pix_col,
    output logic [2:0]                     pix_rgb0,
    output logic [2:0]                     pix_rgb1,
    output logic                           pix_last,
    output logic                           oe_valid,
    output logic [ROW_BITS-1:0]            oe_row,
    output logic [OE_CNT_BITS-1:0]         oe_cycles,
    output logic                           err_short,
    output logic                           err_drop
);

    localparam int COL_BITS = $clog2(PANEL_WIDTH);
    localparam int CNT_BITS = $clog2(PANEL_WIDTH + 1);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(PANEL_WIDTH);
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(PANEL_WIDTH - 1);

    logic [SAMPLE_BITS-1:0] sample_s;
    logic [ROW_BITS-1:0]    row_s;
    logic                   oe_n_s, clk_rise, lat_rise, oe_fall, oe_rise;
    logic [SAMPLE_BITS-1:0] raw_data;

    // Sample bit order follows the colour positions in hub75_pkg.
    always_comb begin
        raw_data         = '0;
        raw_data[R0_POS] = hub75_r0;
        raw_data[G0_POS] = hub75_g0;
        raw_data[B0_POS] = hub75_b0;
        raw_data[R1_POS] = hub75_r1;
        raw_data[G1_POS] = hub75_g1;
        raw_data[B1_POS] = hub75_b1;
    end

    hub75_rx_sync #(
        .ROW_BITS (ROW_BITS)
    ) u_sync (
        .osc_clk    (osc_clk),
        .reset_     (reset_),
        .hub75_clk  (hub75_clk),
        .hub75_lat  (hub75_lat),
        .hub75_oe_  (hub75_oe_),
        .hub75_row  (hub75_row),
        .hub75_data (raw_data),
        .sample_s   (sample_s),
        .row_s      (row_s),
        .oe_n_s     (oe_n_s),
        .clk_rise   (clk_rise),
        .lat_rise   (lat_rise),
        .oe_fall    (oe_fall),
        .oe_rise    (oe_rise)
    );

    logic [SAMPLE_BITS-1:0] shift_buf_q [PANEL_WIDTH];
    logic [SAMPLE_BITS-1:0] shift_buf_d [PANEL_WIDTH];
    logic [SAMPLE_BITS-1:0] hold_buf_q  [PANEL_WIDTH];
    logic [SAMPLE_BITS-1:0] hold_buf_d  [PANEL_WIDTH];

    rx_state_e              state_q, state_d;
    logic [CNT_BITS-1:0]    col_cnt_q, col_cnt_d;
    logic                   pix_valid_q, pix_valid_d;
    logic [ROW_BITS-1:0]    pix_row_q, pix_row_d;
    logic [COL_BITS-1:0]    pix_col_q, pix_col_d;
    logic [2:0]             pix_rgb0_q, pix_rgb0_d;
    logic [2:0]             pix_rgb1_q, pix_rgb1_d;
    logic                   pix_last_q, pix_last_d;
    logic                   err_short_q, err_short_d;
    logic                   err_drop_q, err_drop_d;
    logic [OE_CNT_BITS-1:0] oe_cnt_q, oe_cnt_d;
    logic                   oe_valid_q, oe_valid_d;
    logic [ROW_BITS-1:0]    oe_row_q, oe_row_d;
    logic [OE_CNT_BITS-1:0] oe_cycles_q, oe_cycles_d;

    logic                   wr_en;
    logic [COL_BITS-1:0]    wr_idx;
    logic [CNT_BITS-1:0]    col_shifted;
    logic [COL_BITS-1:0]    next_col;
    logic                   copy_en;

    // Shift write is applied before the latch looks at the buffer and count,
    // so a coincident clock edge is part of the latched line.
    always_comb begin
        wr_en       = clk_rise && (col_cnt_q != FULL_CNT);
        wr_idx      = col_cnt_q[COL_BITS-1:0];
        col_shifted = wr_en ? col_cnt_q + 1'b1 : col_cnt_q;
        shift_buf_d = shift_buf_q;
        if (wr_en) begin
            shift_buf_d[wr_idx] = sample_s;
        end
        copy_en    = lat_rise && (state_q == ST_IDLE);
        hold_buf_d = copy_en ? shift_buf_d : hold_buf_q;
    end

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_shifted;
        pix_valid_d = pix_valid_q;
        pix_row_d   = pix_row_q;
        pix_col_d   = pix_col_q;
        pix_rgb0_d  = pix_rgb0_q;
        pix_rgb1_d  = pix_rgb1_q;
        pix_last_d  = pix_last_q;
        err_short_d = err_short_q;
        err_drop_d  = err_drop_q;
        next_col    = pix_col_q + 1'b1;

        if (state_q == ST_SEND && pix_valid_q && pix_ready) begin
            if (pix_last_q) begin
                state_d     = ST_IDLE;
                pix_valid_d = 1'b0;
            end else begin
                pix_col_d  = next_col;
                pix_rgb0_d = rgb0_of(hold_buf_q[next_col]);
                pix_rgb1_d = rgb1_of(hold_buf_q[next_col]);
                pix_last_d = (next_col == LAST_COL);
            end
        end

        if (lat_rise) begin
            col_cnt_d = '0;
            if (col_shifted != FULL_CNT) begin
                err_short_d = 1'b1;
            end
            if (state_q == ST_IDLE) begin
                state_d     = ST_SEND;
                pix_valid_d = 1'b1;
                pix_row_d   = row_s;
                pix_col_d   = '0;
                pix_rgb0_d  = rgb0_of(shift_buf_d[0]);
                pix_rgb1_d  = rgb1_of(shift_buf_d[0]);
                pix_last_d  = (LAST_COL == '0);
            end else begin
                err_drop_d = 1'b1;
            end
        end
    end

    // Count includes the falling-edge cycle, so the result equals synced low cycles.
    always_comb begin
        oe_cnt_d    = oe_cnt_q;
        oe_valid_d  = oe_rise;
        oe_row_d    = oe_row_q;
        oe_cycles_d = oe_cycles_q;
        if (oe_fall) begin
            oe_cnt_d = OE_CNT_BITS'(1);
        end else if (!oe_n_s && (oe_cnt_q != '1)) begin
            oe_cnt_d = oe_cnt_q + 1'b1;
        end
        if (oe_rise) begin
            oe_cycles_d = oe_cnt_q;
            oe_row_d    = row_s;
        end
    end

    always_ff @(posedge osc_clk) begin
        shift_buf_q <= shift_buf_d;
        hold_buf_q  <= hold_buf_d;
    end

    always_ff @(posedge osc_clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= ST_IDLE;
            col_cnt_q   <= '0;
            pix_valid_q <= 1'b0;
            pix_row_q   <= '0;
            pix_col_q   <= '0;
            pix_rgb0_q  <= '0;
            pix_rgb1_q  <= '0;
            pix_last_q  <= 1'b0;
            err_short_q <= 1'b0;
            err_drop_q  <= 1'b0;
            oe_cnt_q    <= '0;
            oe_valid_q  <= 1'b0;
            oe_row_q    <= '0;
            oe_cycles_q <= '0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            pix_valid_q <= pix_valid_d;
            pix_row_q   <= pix_row_d;
            pix_col_q   <= pix_col_d;
            pix_rgb0_q  <= pix_rgb0_d;
            pix_rgb1_q  <= pix_rgb1_d;
            pix_last_q  <= pix_last_d;
            err_short_q <= err_short_d;
            err_drop_q  <= err_drop_d;
            oe_cnt_q    <= oe_cnt_d;
            oe_valid_q  <= oe_valid_d;
            oe_row_q    <= oe_row_d;
            oe_cycles_q <= oe_cycles_d;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_row   = pix_row_q;
    assign pix_col   = pix_col_q;
    assign pix_rgb0  = pix_rgb0_q;
    assign pix_rgb1  = pix_rgb1_q;
    assign pix_last  = pix_last_q;
    assign oe_valid  = oe_valid_q;
    assign oe_row    = oe_row_q;
    assign oe_cycles = oe_cycles_q;
    assign err_short = err_short_q;
    assign err_drop  = err_drop_q;

endmodule
